envelope_generator: RTL
=======================

// Module: envelope_generator
// PURPOSE
//  Per-voice ADSR envelope generator; produces the voice_volumes[] array consumed by the Synthesizer mixer.
//  Time-multiplexed: one shared step datapath updates one voice per clock, sweeping all voices once per tick.
//  Gate inputs are note-on/off; volumes are unsigned levels 0..ENV_MAX fed directly to the mixer multiply.
// PARAMETERS
//  N_VOICES  8         number of voices (matches mixer)
//  TICK_DIV  48000     clocks per envelope tick; elaboration error if TICK_DIV < N_VOICES+1
//  ENV_MAX   32'h10000 full-scale level (unity volume)
// PORTS
//  clk            in   1        system clock
//  reset          in   1        synchronous, active-high
//  gate           in   N_VOICES per-voice note gate, level-sensitive, async to tick
//  attack_rate    in   32       level increment per tick in ATTACK
//  decay_rate     in   32       level decrement per tick in DECAY
//  sustain_level  in   32       SUSTAIN target; values > ENV_MAX are clamped to ENV_MAX
//  release_rate   in   32       level decrement per tick in RELEASE
//  voice_volumes  out  32 x N_VOICES  registered envelope level per voice (unpacked [N_VOICES-1:0])
//  voice_active   out  N_VOICES registered: 1 when voice state != IDLE
//  sweep_done     out  1        one-cycle pulse, the cycle after voice N_VOICES-1 is written
// BEHAVIOUR
//  Reset: all levels 0, all states IDLE, pending_rise 0, prescaler 0; voice_volumes, voice_active, sweep_done 0.
//  Reset mid-operation: same values next edge; first sweep begins at prescaler 0 after reset deasserts.
//  Prescaler: counts 0..TICK_DIV-1, wraps. When count = v < N_VOICES, voice v is serviced;
//   its new level/state is registered at that edge (visible on voice_volumes[v] the next cycle).
//  Edge capture: gate[i] registered every clock; a rising edge sets pending_rise[i] at any cycle;
//   cleared when voice i is serviced. A rise in the same cycle as service is kept pending for the next tick.
//  Service order per voice (one cycle, combinational step, then register):
//   1. pending_rise        -> state = ATTACK (retrigger from current level, no reset to 0).
//   2. else gate low and state in {ATTACK,DECAY,SUSTAIN} -> state = RELEASE.
//   3. apply state step:
//    ATTACK : lvl = min(lvl + attack_rate, ENV_MAX), 33-bit sum (no wrap); lvl==ENV_MAX -> DECAY.
//    DECAY  : lvl = max(lvl - decay_rate, S) with S = clamped sustain, underflow-safe; lvl==S -> SUSTAIN.
//             lvl already below S -> lvl = S, SUSTAIN.
//    SUSTAIN: lvl = S (follows live sustain_level changes).
//    RELEASE: lvl = max(lvl - release_rate, 0), underflow-safe; lvl==0 -> IDLE.
//    IDLE   : lvl = 0.
//  Rate 0: ATTACK/DECAY/RELEASE hold level indefinitely (no special casing).
//  Short gate pulse (rise and fall between services): guarantees >= 1 ATTACK step, then RELEASE next tick.
//  Worst-case gate-rise to volume change: TICK_DIV + N_VOICES + 2 clocks.
//  Rate/sustain inputs are sampled at the service cycle; changes take effect on the next service.
// STRUCTURE
//  synth_pkg: typedef enum logic[2:0] env_state_t {ENV_IDLE, ENV_ATTACK, ENV_DECAY, ENV_SUSTAIN, ENV_RELEASE};
//   ENV_MAX_DEFAULT constant; shared with mixer for volume scale.
//  Sub-module env_step (combinational): in state, lvl, gate, pending, rates, S -> next state, next lvl.
//   Instantiated once, muxed by voice index. Top holds prescaler, per-voice state/level regs, edge capture.
// TESTING (TICK_DIV=16, N_VOICES=8, ENV_MAX=65536 unless stated)
//  1 reset held 3 clocks -> all voice_volumes 0, voice_active 0, sweep_done 0; sweep_done every 16 clocks after.
//  2 gate[0]=1, attack=16384, decay=8192, sustain=32768 -> vol[0] 16384,32768,49152,65536 over 4 ticks,
//    then 57344,49152,40960,32768, then holds 32768; voice_active[0]=1.
//  3 from (2) gate[0]=0, release=10000 -> 22768,12768,2768,0; voice_active[0]=0 the tick reaching 0.
//  4 retrigger at release level 12768 with attack=16384 -> next tick 29152 (no drop to 0).
//  5 one-clock gate[3] pulse between services, attack=16384, release=4096 -> vol[3] 16384 then 12288; other voices 0.
//  6 attack=32'hFFFF_FFFF -> vol 65536 in one tick (no wrap); release=32'hFFFF_FFFF -> 0 in one tick;
//    sustain_level=32'h20000 -> SUSTAIN holds 65536; assert reset mid-attack -> all zero next cycle.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synthesizer definitions: envelope states and the volume scale used
// by both the envelope generator and the mixer.
package synth_pkg;

  // Unity volume; the mixer multiplies samples by levels in 0..ENV_MAX_DEFAULT.
  localparam logic [31:0] ENV_MAX_DEFAULT = 32'h0001_0000;

  typedef enum logic [2:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_DECAY,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

  // Saturate a level-like input to an upper limit.
  function automatic logic [31:0] clamp_level(input logic [31:0] value,
                                              input logic [31:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/envelope_generator_env_step.sv
// One ADSR step for a single voice: resolves gate/retrigger events into the
// effective state, then applies that state's level update. Purely combinational.
module env_step
  import synth_pkg::*;
#(
  parameter logic [31:0] ENV_MAX = ENV_MAX_DEFAULT
) (
  input  env_state_t  state_in,
  input  logic [31:0] lvl_in,
  input  logic        gate,
  input  logic        pending,
  input  logic [31:0] attack_rate,
  input  logic [31:0] decay_rate,
  input  logic [31:0] sustain_level,
  input  logic [31:0] release_rate,
  output env_state_t  state_out,
  output logic [31:0] lvl_out
);

  logic [31:0] sustain_clamped;
  logic [32:0] attack_sum;
  env_state_t  eff_state;

  assign sustain_clamped = clamp_level(sustain_level, ENV_MAX);
  // One extra bit so a huge attack rate saturates instead of wrapping.
  assign attack_sum      = {1'b0, lvl_in} + {1'b0, attack_rate};

  // Event resolution: a captured rise retriggers from the current level;
  // otherwise a low gate moves any sounding phase into release.
  always_comb begin
    eff_state = state_in;
    if (pending) begin
      eff_state = ENV_ATTACK;
    end else if (!gate && (state_in == ENV_ATTACK || state_in == ENV_DECAY ||
                           state_in == ENV_SUSTAIN)) begin
      eff_state = ENV_RELEASE;
    end
  end

  // Level step for the effective state; every subtraction is guarded so it
  // saturates at its floor rather than underflowing.
  always_comb begin
    state_out = eff_state;
    lvl_out   = lvl_in;
    case (eff_state)
      ENV_ATTACK: begin
        if (attack_sum >= {1'b0, ENV_MAX}) begin
          lvl_out   = ENV_MAX;
          state_out = ENV_DECAY;
        end else begin
          lvl_out = attack_sum[31:0];
        end
      end
      ENV_DECAY: begin
        if (lvl_in <= sustain_clamped || decay_rate >= lvl_in - sustain_clamped) begin
          lvl_out   = sustain_clamped;
          state_out = ENV_SUSTAIN;
        end else begin
          lvl_out = lvl_in - decay_rate;
        end
      end
      ENV_SUSTAIN: begin
        lvl_out = sustain_clamped;
      end
      ENV_RELEASE: begin
        if (release_rate >= lvl_in) begin
          lvl_out   = '0;
          state_out = ENV_IDLE;
        end else begin
          lvl_out = lvl_in - release_rate;
        end
      end
      default: begin
        lvl_out   = '0;
        state_out = ENV_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/envelope_generator.sv
// Time-multiplexed per-voice ADSR envelope generator. A prescaler sweeps the
// voices once per tick; a single env_step datapath serves the selected voice.
module envelope_generator
  import synth_pkg::*;
#(
  parameter int          N_VOICES = 8,
  parameter int          TICK_DIV = 48000,
  parameter logic [31:0] ENV_MAX  = ENV_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_VOICES-1:0] gate,
  input  logic [31:0]         attack_rate,
  input  logic [31:0]         decay_rate,
  input  logic [31:0]         sustain_level,
  input  logic [31:0]         release_rate,
  output logic [31:0]         voice_volumes [N_VOICES-1:0],
  output logic [N_VOICES-1:0] voice_active,
  output logic                sweep_done
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int VW = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  // The sweep needs every voice slot plus at least one idle slot per tick.
  if (TICK_DIV < N_VOICES + 1) begin : g_bad_tick_div
    $error("envelope_generator: TICK_DIV must be at least N_VOICES+1");
  end

  logic [CW-1:0]       count_reg;
  logic                sweep_done_reg;
  logic [N_VOICES-1:0] gate_reg;
  logic [N_VOICES-1:0] pending_vec;
  logic [N_VOICES-1:0] active_vec;
  env_state_t          state_vec [N_VOICES-1:0];
  logic [31:0]         level_vec [N_VOICES-1:0];

  logic                svc_en;
  logic [VW-1:0]       svc_idx;
  env_state_t          step_state;
  logic [31:0]         step_lvl;

  assign svc_en  = (count_reg < CW'(N_VOICES));
  assign svc_idx = VW'(count_reg);

  // Prescaler: counts 0..TICK_DIV-1; the first N_VOICES counts are service slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (count_reg == CW'(TICK_DIV - 1)) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Pulse the cycle after the last voice of the sweep has been written.
  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_done_reg <= 1'b0;
    end else begin
      sweep_done_reg <= (count_reg == CW'(N_VOICES - 1));
    end
  end

  // Gate history for rising-edge detection; also the gate level seen at service.
  always_ff @(posedge clk) begin
    if (reset) begin
      gate_reg <= '0;
    end else begin
      gate_reg <= gate;
    end
  end

  // Shared step datapath, muxed onto the voice selected by the prescaler.
  env_step #(
    .ENV_MAX(ENV_MAX)
  ) u_env_step (
    .state_in     (state_vec[svc_idx]),
    .lvl_in       (level_vec[svc_idx]),
    .gate         (gate_reg[svc_idx]),
    .pending      (pending_vec[svc_idx]),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .sustain_level(sustain_level),
    .release_rate (release_rate),
    .state_out    (step_state),
    .lvl_out      (step_lvl)
  );

  for (genvar gi = 0; gi < N_VOICES; gi++) begin : g_voice
    logic        svc_hit;
    logic        rise;
    env_state_t  state_reg;
    logic [31:0] level_reg;
    logic        active_reg;
    logic        pending_reg;

    assign svc_hit = svc_en && (svc_idx == VW'(gi));
    assign rise    = gate[gi] && !gate_reg[gi];

    // Voice registers: updated only in this voice's slot. A rise seen in the
    // service cycle itself wins over the clear so it is served next tick.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg   <= ENV_IDLE;
        level_reg   <= '0;
        active_reg  <= 1'b0;
        pending_reg <= 1'b0;
      end else begin
        if (svc_hit) begin
          state_reg  <= step_state;
          level_reg  <= step_lvl;
          active_reg <= (step_state != ENV_IDLE);
        end
        if (rise) begin
          pending_reg <= 1'b1;
        end else if (svc_hit) begin
          pending_reg <= 1'b0;
        end
      end
    end

    assign state_vec[gi]     = state_reg;
    assign level_vec[gi]     = level_reg;
    assign pending_vec[gi]   = pending_reg;
    assign active_vec[gi]    = active_reg;
    assign voice_volumes[gi] = level_reg;
  end

  assign voice_active = active_vec;
  assign sweep_done   = sweep_done_reg;

endmodule
